det_window_counter: RTL
=======================

// Module: det_window_counter
// PURPOSE
//  Downstream consumer of the "11" sequence detector's one-bit Mealy output.
//  Counts detector hits over fixed windows of WIN_LEN clock cycles.
//  Hands each window total to the next stage over a valid/ready report port.
//  Flags a report that is lost because the previous one was not yet accepted.
// PARAMETERS
//  WIN_LEN  16  window length in clock cycles; legal range 2..65535
//  CNT_W    8   width of the hit accumulator and of rpt_data
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst        in   1      reset, asynchronous, active-high
//  en         in   1      1 = counting enabled; 0 = idle
//  det        in   1      detector output (y), sampled every clk rising edge
//  rpt_data   out  CNT_W  hit count of the last completed window
//  rpt_sat    out  1      1 = rpt_data is saturated (true count >= 2^CNT_W-1)
//  rpt_valid  out  1      a report is pending
//  rpt_ready  in   1      consumer accepts the report
//  rpt_ovf    out  1      sticky flag: at least one window report was dropped
//  ovf_clr    in   1      synchronous clear of rpt_ovf
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; window counter=0; accumulator=0
//   - rpt_data=0, rpt_sat=0, rpt_valid=0, rpt_ovf=0
//  FSM states:
//   - IDLE: det is ignored; window counter and accumulator held at 0.
//       Goes to COUNT on an edge where en=1; that cycle is window cycle 0.
//   - COUNT: each edge, acc <= sat(acc+hit) and win <= win+1.
//       On win==WIN_LEN-1: final = sat(acc+hit) closes the window.
//       After the close, acc restarts at 0 and win at 0, with no dead cycle.
//       Goes to IDLE on any edge where en=0. The partial window is discarded
//       (acc and win cleared). A pending report is unaffected.
//  Hit and saturation:
//   - hit = det (see CONFIGURATION).
//   - Saturation: accumulator sticks at 2^CNT_W-1.
//   - rpt_sat = 1 if the accumulator reached 2^CNT_W-1 during the window.
//  Report latency and handshake:
//   - A window spanning cycles k..k+WIN_LEN-1 gives rpt_valid=1 from cycle
//     k+WIN_LEN. rpt_data and rpt_sat are loaded on that same edge.
//   - rpt_valid, rpt_data and rpt_sat stay stable until an edge with
//     rpt_valid & rpt_ready. rpt_valid then drops, unless a new window
//     closes on that same edge, in which case the new report loads and
//     rpt_valid stays 1 with no ovf.
//   - Close while rpt_valid=1 and rpt_ready=0: the new report is dropped,
//     the old one is kept, and rpt_ovf <= 1.
//   - rpt_ready while rpt_valid=0 has no effect.
//  rpt_ovf:
//   - ovf_clr=1 clears it on the next edge.
//   - If set and clear happen on the same edge, set wins.
//  Reset mid-window or with a report pending: everything clears immediately.
//   No report is produced.
// CONFIGURATION
//  DET_EDGE_ONLY_EN defined:
//   - hit = det & ~det_q, where det_q is det registered in COUNT.
//   - det_q is forced to 0 in IDLE and by reset, so det=1 on window cycle 0
//     after IDLE counts.
//   - det_q carries across window boundaries. A run of 1s spanning a window
//     boundary counts once, in the window where it started.
//   - Net effect: a run of consecutive detector hits (input "111...")
//     counts once.
//  DET_EDGE_ONLY_EN undefined: hit = det; every cycle with det=1 counts.
//   No det_q register is built.
// TESTING
//  1. rst=1 with en=1, det=1 for 5 cycles
//     -> rpt_valid=0, rpt_data=0, rpt_ovf=0; no report until 16 cycles
//        after release.
//  2. WIN_LEN=16, en=1, det=1 for 16 cycles, rpt_ready=1
//     -> rpt_valid=1 for one cycle at cycle 16; rpt_data=16 (macro off)
//        or 1 (macro on).
//  3. det=0,1,1,1,0,1,1,0 then 0s for the rest of the window
//     -> rpt_data=5 (off) or 2 (on); rpt_sat=0.
//  4. CNT_W=4, det=1 for the whole window, macro off
//     -> rpt_data=15, rpt_sat=1.
//  5. rpt_ready=0 for two windows
//     -> first report held unchanged; rpt_ovf=1 after the second close.
//     Then ovf_clr=1 -> rpt_ovf=0.
//     ovf_clr on the same edge as a drop -> rpt_ovf stays 1.
//  6. en=0 at window cycle 7, en=1 two cycles later
//     -> no report for the partial window; next rpt_valid 16 cycles after
//        re-entry.
//     rpt_ready=1 on a close edge with one report pending
//     -> new data loads, rpt_valid stays 1, rpt_ovf=0.

Source files
------------

// File: rtl/det_window_counter.sv
// det_window_counter: counts "11"-detector hits over fixed windows and
// reports each window total over a valid/ready port, flagging dropped reports.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   en                   1 = counting, 0 = idle (partial window discarded)
//   det                  detector output, sampled every rising edge
//   rpt_data/rpt_sat     last completed window count / saturation flag
//   rpt_valid/rpt_ready  report handshake
//   rpt_ovf/ovf_clr      sticky dropped-report flag / synchronous clear
//
// Optional build macro: DET_EDGE_ONLY_EN
//   defined   -> only the rising edge of a run of det=1 counts as a hit
//   undefined -> every cycle with det=1 counts

module det_window_counter #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det,
    output logic [CNT_W-1:0] rpt_data,
    output logic             rpt_sat,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic             rpt_ovf,
    input  logic             ovf_clr
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] ACC_MAX  = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             w_run;
    logic             w_hit;
    logic             w_close;
    logic             w_load;
    logic             w_drop;
    logic [CNT_W-1:0] w_acc_sum;

    logic [WIN_W-1:0] r_win;
    logic [CNT_W-1:0] r_acc;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = en ? S_COUNT : S_IDLE;
            S_COUNT: w_state_nxt = en ? S_COUNT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The edge where en is first seen in IDLE is already window cycle 0,
    // so counting is active in either state whenever en is high.
    always_comb begin
        w_run = 1'b0;
        unique case (r_state)
            S_IDLE:  w_run = en;
            S_COUNT: w_run = en;
            default: w_run = 1'b0;
        endcase
    end

    // ---------------- hit generation ----------------
`ifdef DET_EDGE_ONLY_EN
    logic r_det_q;
    logic w_prev_det;

    // det_q survives window boundaries but is zero outside COUNT, so a
    // run of 1s counts once, in the window where it began.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_q <= 1'b0;
        end else begin
            r_det_q <= w_run & det;
        end
    end

    assign w_prev_det = r_det_q & (r_state == S_COUNT);
    assign w_hit      = det & ~w_prev_det;
`else
    assign w_hit = det;
`endif

    // ---------------- window / accumulator ----------------
    assign w_acc_sum = (r_acc == ACC_MAX) ? ACC_MAX
                                          : r_acc + CNT_W'(w_hit);
    assign w_close   = w_run & (r_win == WIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
            r_acc <= '0;
        end else if (!w_run || w_close) begin
            r_win <= '0;
            r_acc <= '0;
        end else begin
            r_win <= r_win + WIN_W'(1);
            r_acc <= w_acc_sum;
        end
    end

    // ---------------- report port ----------------
    // A close with the slot free (or being freed this edge) loads;
    // a close with an unaccepted report pending is dropped.
    assign w_load = w_close & (~rpt_valid | rpt_ready);
    assign w_drop = w_close & rpt_valid & ~rpt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_valid <= 1'b0;
            rpt_data  <= '0;
            rpt_sat   <= 1'b0;
        end else if (w_load) begin
            rpt_valid <= 1'b1;
            rpt_data  <= w_acc_sum;
            rpt_sat   <= (w_acc_sum == ACC_MAX);
        end else if (rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

    // Set has priority over a same-edge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_ovf <= 1'b0;
        end else if (w_drop) begin
            rpt_ovf <= 1'b1;
        end else if (ovf_clr) begin
            rpt_ovf <= 1'b0;
        end
    end

endmodule
